// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax subtract blocks.
// FSM encoding, default widths and a saturating subtract helper.
package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_LN_SHIFT = 6;

    // a - b clamped to the signed range of a w-bit word
    function automatic logic signed [63:0] sat_sub(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] d;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        d  = a - b;
        if (d > hi) begin
            return hi;
        end else if (d < lo) begin
            return lo;
        end
        return d;
    endfunction

endpackage

// File: rtl/sub_2_stream_if.sv
// Stream bundle between the downscale/ln producers and the subtractor.
// master drives the inputs and ready, slave is the subtractor.
interface sub_2_stream_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
);
    logic [DATA_W-1:0] ds_data_i;
    logic              ds_data_valid_i;
    logic [CNT_W-1:0]  ds_number_of_data_i;
    logic [DATA_W-1:0] ln_data_i;
    logic              ln_data_valid_i;
    logic [DATA_W-1:0] sub_data_o;
    logic              sub_data_valid_o;
    logic              sub_data_ready_i;
    logic              sub_done_o;
    logic              overflow_o;

    modport master (
        output ds_data_i, ds_data_valid_i, ds_number_of_data_i,
        output ln_data_i, ln_data_valid_i, sub_data_ready_i,
        input  sub_data_o, sub_data_valid_o, sub_done_o, overflow_o
    );

    modport slave (
        input  ds_data_i, ds_data_valid_i, ds_number_of_data_i,
        input  ln_data_i, ln_data_valid_i, sub_data_ready_i,
        output sub_data_o, sub_data_valid_o, sub_done_o, overflow_o
    );
endinterface

// File: rtl/sub_2_stream_buf.sv
// Element buffer: one synchronous write port, one asynchronous read.
// Contents are not reset; the reader never passes the writer.
module sub_2_stream_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clock_i,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // store one element per accepted write
    always_ff @(posedge clock_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sub_2_stream.sv
// Streams y[k] = x[k] - (ln >>> LN_SHIFT) for one frame at a time.
// Elements may arrive before or during the run; output has valid/ready.
module sub_2_stream
    import softmax_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 16,
    parameter int LN_SHIFT = DEF_LN_SHIFT,
    parameter int SATURATE = 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input logic           clock_i,
    input logic           reset_i,
    sub_2_stream_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   n_q;
    logic [DATA_W-1:0]  ln_q;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               done_q;
    logic               ovf_q;

    logic [CNT_W-1:0]   wr_base;
    logic               full;
    logic               wr_en;
    logic               accept;
    logic               issue;
    logic               last;
    logic [DATA_W-1:0]  rd_data;
    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] ln_sh;
    logic [DATA_W-1:0]  y_sat;
    logic [DATA_W-1:0]  y_wrap;
    logic [DATA_W-1:0]  y;

    sub_2_stream_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clock_i (clock_i),
        .we      (wr_en),
        .waddr   (wr_base[AW-1:0]),
        .wdata   (bus.ds_data_i),
        .raddr   (rd_cnt[AW-1:0]),
        .rdata   (rd_data)
    );

    // write slot, issue/accept decisions and the subtract datapath
    always_comb begin
        wr_base = (state == ST_DONE) ? '0 : wr_cnt;
        full    = (wr_base == DEPTH_C);
        wr_en   = bus.ds_data_valid_i && !full;
        accept  = valid_q && bus.sub_data_ready_i;
        issue   = (state == ST_RUN) && (rd_cnt < wr_cnt)
                  && (rd_cnt < n_q)
                  && (!valid_q || bus.sub_data_ready_i);
        last    = (state == ST_RUN) && accept && (rd_cnt == n_q);
        x_s     = $signed(rd_data);
        ln_sh   = $signed(ln_q) >>> LN_SHIFT;
        y_sat   = DATA_W'(sat_sub(64'(x_s), 64'(ln_sh), DATA_W));
        y_wrap  = DATA_W'(x_s - ln_sh);
        y       = (SATURATE != 0) ? y_sat : y_wrap;
    end

    // frame FSM with counters and registered outputs
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= ST_IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            n_q     <= '0;
            ln_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.ds_data_valid_i && full) begin
                ovf_q <= 1'b1;
            end
            wr_cnt <= wr_en ? wr_base + ONE : wr_base;
            if (issue) begin
                data_q  <= y;
                valid_q <= 1'b1;
                rd_cnt  <= rd_cnt + ONE;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (bus.ln_data_valid_i) begin
                        ln_q <= bus.ln_data_i;
                        n_q  <= (bus.ds_number_of_data_i > DEPTH_C)
                                ? DEPTH_C : bus.ds_number_of_data_i;
                        if (bus.ds_number_of_data_i == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    rd_cnt <= '0;
                    ln_q   <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sub_data_o       = data_q;
    assign bus.sub_data_valid_o = valid_q;
    assign bus.sub_done_o       = done_q;
    assign bus.overflow_o       = ovf_q;
endmodule

// File: tb/tb_sub_2_stream.sv
// Bench for sub_2_stream: two instances share one stimulus stream,
// dut_a saturating with DEPTH 16, dut_b wrapping with DEPTH 4.
module tb_sub_2_stream;
    import softmax_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ds_data = '0;
    logic        ds_valid = 1'b0;
    logic [4:0]  n = '0;
    logic [15:0] ln = '0;
    logic        ln_valid = 1'b0;
    logic        ready = 1'b1;
    int          rdy_mode = 0;

    int pass = 0;
    int total = 0;
    int cyc = 0;
    int done_a = 0;
    int done_b = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          ta[$];

    logic        pv_a, pr_a, pv_b, pr_b;
    logic [15:0] pd_a, pd_b;

    sub_2_stream_if #(.DATA_W(16), .CNT_W(5)) ifa ();
    sub_2_stream_if #(.DATA_W(16), .CNT_W(3)) ifb ();

    assign ifa.ds_data_i           = ds_data;
    assign ifa.ds_data_valid_i     = ds_valid;
    assign ifa.ds_number_of_data_i = n;
    assign ifa.ln_data_i           = ln;
    assign ifa.ln_data_valid_i     = ln_valid;
    assign ifa.sub_data_ready_i    = ready;
    assign ifb.ds_data_i           = ds_data;
    assign ifb.ds_data_valid_i     = ds_valid;
    assign ifb.ds_number_of_data_i = n[2:0];
    assign ifb.ln_data_i           = ln;
    assign ifb.ln_data_valid_i     = ln_valid;
    assign ifb.sub_data_ready_i    = ready;

    sub_2_stream #(
        .DATA_W(16), .DEPTH(16), .LN_SHIFT(6), .SATURATE(1)
    ) dut_a (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (ifa)
    );

    sub_2_stream #(
        .DATA_W(16), .DEPTH(4), .LN_SHIFT(6), .SATURATE(0)
    ) dut_b (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    // spec arithmetic on plain integers
    function automatic logic [15:0] model(input logic [15:0] x,
                                          input logic [15:0] l,
                                          input bit sat);
        int d;
        d = int'($signed(x)) - (int'($signed(l)) >>> 6);
        if (sat) begin
            if (d > 32767) d = 32767;
            else if (d < -32768) d = -32768;
        end
        return d[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            k++;
            case (rdy_mode)
                1: ready = 1'($urandom_range(0, 1));
                2: ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pv_a && !pr_a) begin
                chk("hold_a_valid", 32'(ifa.sub_data_valid_o), 1);
                chk("hold_a_data", 32'(ifa.sub_data_o), 32'(pd_a));
            end
            if (pv_b && !pr_b) begin
                chk("hold_b_valid", 32'(ifb.sub_data_valid_o), 1);
                chk("hold_b_data", 32'(ifb.sub_data_o), 32'(pd_b));
            end
            if (ifa.sub_data_valid_o && ready) begin
                qa.push_back(ifa.sub_data_o);
                ta.push_back(cyc);
            end
            if (ifb.sub_data_valid_o && ready) qb.push_back(ifb.sub_data_o);
            if (ifa.sub_done_o) done_a++;
            if (ifb.sub_done_o) done_b++;
        end
        pv_a = ifa.sub_data_valid_o;
        pd_a = ifa.sub_data_o;
        pr_a = ready;
        pv_b = ifb.sub_data_valid_o;
        pd_b = ifb.sub_data_o;
        pr_b = ready;
    end

    task automatic frame(input logic [15:0] xs[$], input int nn,
                         input logic [15:0] lnv, input int ln_at);
        int da0, db0, k, ea, eb;
        qa.delete();
        qb.delete();
        ta.delete();
        da0 = done_a;
        db0 = done_b;
        for (int i = 0; i < xs.size(); i++) begin
            ds_data  = xs[i];
            ds_valid = 1'b1;
            if (i == ln_at) begin
                n = 5'(nn);
                ln = lnv;
                ln_valid = 1'b1;
            end
            tick();
            ds_valid = 1'b0;
            ln_valid = 1'b0;
        end
        if (ln_at >= xs.size()) begin
            n = 5'(nn);
            ln = lnv;
            ln_valid = 1'b1;
            tick();
            ln_valid = 1'b0;
        end
        k = 0;
        while ((done_a == da0 || done_b == db0) && k < 400) begin
            tick();
            k++;
        end
        if (k == 400) begin
            total++;
            $display("FAIL frame_timeout actual=no_done required=done");
        end
        repeat (3) tick();
        ea = (nn < 16) ? nn : 16;
        eb = (nn < 4) ? nn : 4;
        chk("done_a_pulses", done_a - da0, 1);
        chk("done_b_pulses", done_b - db0, 1);
        chk("count_a", qa.size(), ea);
        chk("count_b", qb.size(), eb);
        for (int i = 0; i < ea && i < qa.size(); i++)
            chk("y_a", 32'(qa[i]), 32'(model(xs[i], lnv, 1'b1)));
        for (int i = 0; i < eb && i < qb.size(); i++)
            chk("y_b", 32'(qb[i]), 32'(model(xs[i], lnv, 1'b0)));
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] l;
        logic [15:0] ya;
        logic [15:0] yb;
    } vec_t;

    initial begin
        vec_t        tab[6];
        logic [15:0] xs[$];
        int          k;
        int          nn;

        tab[0] = '{16'h0100, 16'h0400, 16'h00F0, 16'h00F0};
        tab[1] = '{16'h8000, 16'h0040, 16'h8000, 16'h7FFF};
        tab[2] = '{16'h7FFF, 16'hFFC0, 16'h7FFF, 16'h8000};
        tab[3] = '{16'h8001, 16'h0080, 16'h8000, 16'h7FFF};
        tab[4] = '{16'h1234, 16'h0000, 16'h1234, 16'h1234};
        tab[5] = '{16'h0005, 16'hFFFF, 16'h0006, 16'h0006};

        repeat (2) tick();
        chk("rst_valid", 32'(ifa.sub_data_valid_o), 0);
        chk("rst_data", 32'(ifa.sub_data_o), 0);
        chk("rst_done", 32'(ifa.sub_done_o), 0);
        chk("rst_ovf", 32'(ifa.overflow_o), 0);
        rst = 1'b0;
        tick();

        // basic three-element frame, continuous ready
        rdy_mode = 0;
        xs = {16'h0100, 16'h0200, 16'h0000};
        frame(xs, 3, 16'h0400, 3);
        chk("basic_y0", 32'(qa[0]), 32'h00F0);
        chk("basic_y1", 32'(qa[1]), 32'h01F0);
        chk("basic_y2", 32'(qa[2]), 32'hFFF0);
        if (ta.size() == 3) chk("basic_consec", ta[2] - ta[0], 2);
        else chk("basic_consec_n", ta.size(), 3);

        // table of single-element frames
        for (int i = 0; i < 6; i++) begin
            xs = {tab[i].x};
            frame(xs, 1, tab[i].l, i % 2);
            chk("tab_a", 32'(qa[0]), 32'(tab[i].ya));
            chk("tab_b", 32'(qb[0]), 32'(tab[i].yb));
        end

        // backpressure pattern 1,0,0,1
        rdy_mode = 2;
        xs = {16'h0011, 16'hF000, 16'h7000, 16'h0042};
        frame(xs, 4, 16'h1000, 0);

        // overflow: ln after first write, five writes, N=4
        rdy_mode = 0;
        xs = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        frame(xs, 4, 16'h0040, 1);
        chk("ovf_b", 32'(ifb.overflow_o), 1);
        chk("ovf_a", 32'(ifa.overflow_o), 0);

        // N=0: done only
        xs.delete();
        frame(xs, 0, 16'h0400, 0);
        chk("n0_idle", 32'(dut_a.state), 32'(ST_IDLE));

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            nn = $urandom_range(1, 4);
            xs.delete();
            for (int i = 0; i < nn; i++) xs.push_back(16'($urandom));
            rdy_mode = $urandom_range(0, 2);
            frame(xs, nn, 16'($urandom), $urandom_range(0, nn));
        end

        // reset after two of five outputs
        rdy_mode = 0;
        qa.delete();
        qb.delete();
        xs = {16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
        for (int i = 0; i < 5; i++) begin
            ds_data = xs[i];
            ds_valid = 1'b1;
            tick();
        end
        ds_valid = 1'b0;
        n = 5'd5;
        ln = 16'h0400;
        ln_valid = 1'b1;
        tick();
        ln_valid = 1'b0;
        k = 0;
        while (qa.size() < 2 && k < 100) begin
            tick();
            k++;
        end
        chk("rst_mid_seen2", qa.size(), 2);
        rst = 1'b1;
        #1;
        chk("mid_valid_a", 32'(ifa.sub_data_valid_o), 0);
        chk("mid_data_a", 32'(ifa.sub_data_o), 0);
        chk("mid_done_a", 32'(ifa.sub_done_o), 0);
        chk("mid_valid_b", 32'(ifb.sub_data_valid_o), 0);
        chk("mid_data_b", 32'(ifb.sub_data_o), 0);
        chk("mid_ovf_b", 32'(ifb.overflow_o), 0);
        tick();
        rst = 1'b0;
        tick();
        xs = {16'h0300, 16'hFF00};
        frame(xs, 2, 16'h0200, 2);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
